// File: rtl/quad_encoder_pkg.sv
// Shared constants, types and the x4 step decoder for the quadrature front end.
package quad_encoder_pkg;

    // Filtered {A,B} levels along the up-counting sequence 00 -> 01 -> 11 -> 10 -> 00.
    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

    typedef enum logic {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } dec_state_t;

    // Speed clamp limits, held at accumulator width so comparisons stay signed.
    localparam logic signed [31:0] SPEED_MAX = 32'sd32767;
    localparam logic signed [31:0] SPEED_MIN = -32'sd32768;

    typedef struct packed {
        logic signed [1:0] delta;    // -1, 0 or +1
        logic              illegal;  // both channels moved in one step
    } step_t;

    function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
        step_t s;
        s.delta   = 2'sb00;
        s.illegal = 1'b0;
        if (prev != cur) begin
            if ((prev ^ cur) == 2'b11)
                s.illegal = 1'b1;
            else if ((prev == AB_00 && cur == AB_01) || (prev == AB_01 && cur == AB_11) ||
                     (prev == AB_11 && cur == AB_10) || (prev == AB_10 && cur == AB_00))
                s.delta = 2'sb01;
            else
                s.delta = 2'sb11;
        end
        return s;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > SPEED_MAX)
            return 16'sh7FFF;
        else if (v < SPEED_MIN)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/quad_encoder_frontend_if.sv
// Result bus from the encoder front end towards the encoder and RPM conduits.
interface quad_encoder_frontend_if;
    logic signed [31:0] position;
    logic signed [15:0] speed;
    logic               speed_valid;
    logic               dir;
    logic               err;

    modport master (output position, speed, speed_valid, dir, err);
    modport slave  (input  position, speed, speed_valid, dir, err);
endinterface

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a stability filter for one encoder channel.
module quad_input_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    // Counter wraps at FILTER_LEN-1: the flip happens on the FILTER_LEN-th disagreeing sample.
    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [1:0] sync;
    logic [3:0] cnt;

    // Synchronize the pin, then only follow it after FILTER_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/quad_encoder_frontend.sv
// Quadrature front end: per-channel conditioning, x4 decode, position count and gated speed.
module quad_encoder_frontend #(
    parameter int FILTER_LEN  = 4,
    parameter int GATE_CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enc_a,
    input  logic enc_b,
    input  logic clear,
    quad_encoder_frontend_if.master bus
);
    import quad_encoder_pkg::*;

    localparam int               GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [4:0]        WARM_LAST = 5'(FILTER_LEN + 2);

    logic [1:0]         raw_ab, filt_ab, cur_ab, prev_ab;
    logic [4:0]         warm_cnt;
    dec_state_t         state, state_nxt;
    step_t              step;
    logic [31:0]        delta32;
    logic signed [31:0] acc, acc_next;
    logic [GATE_W-1:0]  gate_cnt;

    assign raw_ab = {enc_a, enc_b};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_ab[ch]),
            .level (filt_ab[ch])
        );
    end

    // Decoder state register
    always_ff @(posedge clk) begin
        if (reset) state <= WARMUP;
        else       state <= state_nxt;
    end

    // Leave warmup after FILTER_LEN+3 cycles; decode only while running
    always_comb begin
        state_nxt = state;
        step      = '0;
        if (state == WARMUP) begin
            if (warm_cnt == WARM_LAST) state_nxt = RUN;
        end else begin
            step = decode_step(prev_ab, cur_ab);
        end
    end

    // Warmup timer, decoder input register and previous-state tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= '0;
            cur_ab   <= AB_00;
            prev_ab  <= AB_00;
        end else begin
            cur_ab <= filt_ab;
            if (state == WARMUP) begin
                warm_cnt <= warm_cnt + 5'd1;
                // Load from filt_ab (same value cur_ab takes this edge) so a level
                // settling at the end of warmup is not mistaken for motion.
                if (warm_cnt == WARM_LAST) prev_ab <= filt_ab;
            end else begin
                prev_ab <= cur_ab;
            end
        end
    end

    assign delta32  = {{30{step.delta[1]}}, step.delta};
    assign acc_next = acc + delta32;

    // Position, direction, error flag and windowed speed; clear wins over edges and terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.position    <= '0;
            bus.speed       <= '0;
            bus.speed_valid <= 1'b0;
            bus.dir         <= 1'b0;
            bus.err         <= 1'b0;
            acc             <= '0;
            gate_cnt        <= '0;
        end else begin
            bus.speed_valid <= 1'b0;
            if (clear) begin
                bus.position <= '0;
                bus.err      <= 1'b0;
                acc          <= '0;
                gate_cnt     <= '0;
            end else begin
                if (step.illegal) bus.err <= 1'b1;
                if (step.delta != 2'sb00) begin
                    bus.position <= bus.position + delta32;
                    bus.dir      <= ~step.delta[1];
                end
                if (gate_cnt == GATE_LAST) begin
                    // Terminal delta is reported here and then dropped from the next window.
                    bus.speed       <= sat16(acc_next);
                    bus.speed_valid <= 1'b1;
                    acc             <= '0;
                    gate_cnt        <= '0;
                end else begin
                    acc      <= acc_next;
                    gate_cnt <= gate_cnt + GATE_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_frontend.sv
// Directed bench: DUT A (FILTER_LEN=4, short gate) for decode/filter/clear/reset,
// DUT B (FILTER_LEN=1, gate long enough to saturate) for speed limits and pulse spacing.
module tb_quad_encoder_frontend;
    localparam int FL_A = 4, GATE_A = 2000;
    localparam int FL_B = 1, GATE_B = 33000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic rst_a = 1'b1, a_a = 1'b0, b_a = 1'b0, clr_a = 1'b0;
    logic rst_b = 1'b1, a_b = 1'b0, b_b = 1'b0, clr_b = 1'b0;

    quad_encoder_frontend_if ia();
    quad_encoder_frontend_if ib();

    quad_encoder_frontend #(.FILTER_LEN(FL_A), .GATE_CYCLES(GATE_A)) dut_a (
        .clk(clk), .reset(rst_a), .enc_a(a_a), .enc_b(b_a), .clear(clr_a), .bus(ia));
    quad_encoder_frontend #(.FILTER_LEN(FL_B), .GATE_CYCLES(GATE_B)) dut_b (
        .clk(clk), .reset(rst_b), .enc_a(a_b), .enc_b(b_b), .clear(clr_b), .bus(ib));

    // Up-counting order of {A,B}
    logic [1:0] quad [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    typedef struct {
        logic [1:0]  ab;
        logic        clr;
        logic [31:0] pos;
        logic        dir;
        logic        err;
    } vec_t;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic run_a();
        vec_t tbl [11];
        int pidx;
        int nv;
        tbl[0]  = '{2'b01, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        tbl[2]  = '{2'b00, 1'b0, 32'h0000_0001, 1'b1, 1'b1};
        tbl[3]  = '{2'b01, 1'b0, 32'h0000_0002, 1'b1, 1'b1};
        tbl[4]  = '{2'b00, 1'b0, 32'h0000_0001, 1'b0, 1'b1};
        tbl[5]  = '{2'b00, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
        tbl[8]  = '{2'b01, 1'b1, 32'h0000_0000, 1'b0, 1'b0};
        tbl[9]  = '{2'b11, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
        tbl[10] = '{2'b01, 1'b0, 32'h0000_0000, 1'b0, 1'b0};

        // Reset state
        rst_a = 1'b1;
        tick(3);
        chk("a_rst_pos", ia.position, 32'd0);
        chk("a_rst_speed", {16'd0, ia.speed}, 32'd0);
        chk("a_rst_sv", ia.speed_valid, 1'b0);
        chk("a_rst_dir", ia.dir, 1'b0);
        chk("a_rst_err", ia.err, 1'b0);
        rst_a = 1'b0;
        tick(10);

        // Three-sample glitch on A is rejected
        a_a = 1'b1; tick(3); a_a = 1'b0; tick(12);
        chk("glitch_pos", ia.position, 32'd0);
        chk("glitch_err", ia.err, 1'b0);

        // Clean 00->01 step lands exactly FILTER_LEN+3 edges after first sampling edge
        b_a = 1'b1;
        tick(FL_A + 3);
        chk("lat_early_pos", ia.position, 32'd0);
        tick(1);
        chk("lat_pos", ia.position, 32'd1);
        chk("lat_dir", ia.dir, 1'b1);
        pidx = 1;

        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        chk("clr_pos", ia.position, 32'd0);

        // Forward run: 100 full cycles, 20 clk per phase
        for (int i = 0; i < 400; i++) begin
            pidx = (pidx + 1) % 4; {a_a, b_a} = quad[pidx]; tick(20);
        end
        chk("fwd_pos", ia.position, 32'd400);
        chk("fwd_dir", ia.dir, 1'b1);
        chk("fwd_err", ia.err, 1'b0);

        // Reverse run: 101 full cycles
        for (int i = 0; i < 404; i++) begin
            pidx = (pidx + 3) % 4; {a_a, b_a} = quad[pidx]; tick(20);
        end
        chk("rev_pos", ia.position, 32'hFFFF_FFFC);
        chk("rev_dir", ia.dir, 1'b0);
        chk("rev_err", ia.err, 1'b0);

        // Table: single steps, illegal jumps, sticky err and clear
        for (int i = 0; i < 11; i++) begin
            {a_a, b_a} = tbl[i].ab; clr_a = tbl[i].clr;
            tick(1);
            clr_a = 1'b0;
            tick(12);
            chk($sformatf("tbl%0d_pos", i), ia.position, tbl[i].pos);
            chk($sformatf("tbl%0d_dir", i), ia.dir, tbl[i].dir);
            chk($sformatf("tbl%0d_err", i), ia.err, tbl[i].err);
        end
        pidx = 1;

        // Speed: clear aligns the gate, then one forward edge every 40 clk -> 50 edges per window
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        for (int i = 0; i < 50; i++) begin
            pidx = (pidx + 1) % 4; {a_a, b_a} = quad[pidx]; tick(40);
        end
        chk("mid_sv", ia.speed_valid, 1'b1);
        chk("mid_speed", {16'd0, ia.speed}, 32'd50);
        tick(1);
        chk("mid_sv_width", ia.speed_valid, 1'b0);

        // Reverse edge and clear both hit the next terminal cycle: edge and report discarded
        tick(GATE_A - 9);
        pidx = (pidx + 3) % 4; {a_a, b_a} = quad[pidx];
        tick(FL_A + 3);
        clr_a = 1'b1; tick(1); clr_a = 1'b0;
        chk("clrterm_sv", ia.speed_valid, 1'b0);
        chk("clrterm_speed", {16'd0, ia.speed}, 32'd50);
        chk("clrterm_pos", ia.position, 32'd0);
        chk("clrterm_dir", ia.dir, 1'b1);
        nv = 0;
        for (int i = 0; i < GATE_A - 1; i++) begin
            tick(1);
            if (ia.speed_valid) nv++;
        end
        chk("clrterm_quiet", nv, 32'd0);
        tick(1);
        chk("restart_sv", ia.speed_valid, 1'b1);
        chk("restart_speed", {16'd0, ia.speed}, 32'd0);
        chk("restart_pos", ia.position, 32'd0);

        // Reset during motion
        for (int i = 0; i < 3; i++) begin
            pidx = (pidx + 1) % 4; {a_a, b_a} = quad[pidx]; tick(10);
        end
        chk("pre_rst_pos", ia.position, 32'd3);
        pidx = (pidx + 1) % 4; {a_a, b_a} = quad[pidx];
        tick(2);
        rst_a = 1'b1; tick(1);
        chk("mid_rst_pos", ia.position, 32'd0);
        chk("mid_rst_speed", {16'd0, ia.speed}, 32'd0);
        chk("mid_rst_sv", ia.speed_valid, 1'b0);
        chk("mid_rst_dir", ia.dir, 1'b0);
        chk("mid_rst_err", ia.err, 1'b0);
        tick(2);
        rst_a = 1'b0;
        tick(FL_A + 3);
        chk("warm_pos", ia.position, 32'd0);
        chk("warm_err", ia.err, 1'b0);
        tick(10);
        chk("post_warm_pos", ia.position, 32'd0);
        chk("post_warm_err", ia.err, 1'b0);
        pidx = (pidx + 1) % 4; {a_a, b_a} = quad[pidx];
        tick(FL_A + 3);
        chk("post_rst_early", ia.position, 32'd0);
        tick(1);
        chk("post_rst_pos", ia.position, 32'd1);
        chk("post_rst_dir", ia.dir, 1'b1);
    endtask

    task automatic run_b();
        int pidx;
        int nv;
        int unsigned c1, c2;
        c1 = 0; c2 = 0;
        rst_b = 1'b1;
        tick(3);
        chk("b_rst_pos", ib.position, 32'd0);
        chk("b_rst_speed", {16'd0, ib.speed}, 32'd0);
        rst_b = 1'b0;
        tick(10);
        pidx = 0;

        // Window 1: forward edge every clk -> far above +32767
        clr_b = 1'b1; tick(1); clr_b = 1'b0;
        nv = 0;
        for (int i = 0; i < GATE_B; i++) begin
            pidx = (pidx + 1) % 4; {a_b, b_b} = quad[pidx]; tick(1);
            if (ib.speed_valid) begin nv++; c1 = cyc; end
        end
        chk("sat_hi_pulses", nv, 32'd1);
        chk("sat_hi_sv", ib.speed_valid, 1'b1);
        chk("sat_hi_speed", {16'd0, ib.speed}, 32'h0000_7FFF);

        // Window 2: reverse every clk -> far below -32768
        nv = 0;
        for (int i = 0; i < GATE_B; i++) begin
            pidx = (pidx + 3) % 4; {a_b, b_b} = quad[pidx]; tick(1);
            if (ib.speed_valid) begin nv++; c2 = cyc; end
        end
        chk("sat_lo_pulses", nv, 32'd1);
        chk("sat_lo_sv", ib.speed_valid, 1'b1);
        chk("sat_lo_speed", {16'd0, ib.speed}, 32'h0000_8000);
        chk("sv_interval", c2 - c1, GATE_B);
        chk("b_dir", ib.dir, 1'b0);
    endtask

    initial begin
        fork
            run_a();
            run_b();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
